// File: rtl/split_memory_pkg.sv
// Shared types and sizing for the split-macro burst writer.
// Two 512-word macros form one 1024-word logical space; bit 9 of the word address picks the macro.
package split_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MEM_ADDR_W  = 9;
    localparam int MEM_DEPTH   = 512;
    localparam int TOTAL_DEPTH = 1024;
    localparam int MAX_COUNT   = 1024;

endpackage

// File: rtl/split_memory_writer.sv
// Streams a burst of words into two write-only SRAM macros: one word per cycle, and each write appears one cycle after it is accepted.
// Backpressure: s_ready is high only in RUN and drops while abort is high; s_valid low stalls the burst for as long as it stays low.
module split_memory_writer
    import split_memory_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_wmask,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  csb_mem0,
    output logic                  web_mem0,
    output logic [DATA_W/8-1:0]   wmask_mem0,
    output logic [ADDR_W-2:0]     addr_mem0,
    output logic [DATA_W-1:0]     din_mem0,
    output logic                  csb_mem1,
    output logic                  web_mem1,
    output logic [DATA_W/8-1:0]   wmask_mem1,
    output logic [ADDR_W-2:0]     addr_mem1,
    output logic [DATA_W-1:0]     din_mem1
);

    localparam logic [ADDR_W:0] COUNT_LIMIT = (ADDR_W+1)'(MAX_COUNT);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W:0]     remaining;
    logic [ADDR_W:0]     count_clamped;
    logic                accept;
    logic                sel_mem1;

    assign count_clamped = (word_count > COUNT_LIMIT) ? COUNT_LIMIT : word_count;
    assign accept        = s_valid && s_ready;
    assign sel_mem1      = addr_cnt[ADDR_W-1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (count_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept && remaining == (ADDR_W+1)'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == ST_RUN) && !abort;
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            addr_cnt  <= '0;
            remaining <= '0;
        end else if (state == ST_IDLE && start) begin
            addr_cnt  <= start_addr;
            remaining <= count_clamped;
        end else if (accept) begin
            addr_cnt  <= addr_cnt + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Address, data and mask only move on a write to that macro; idle cycles hold them.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csb_mem0   <= 1'b1;
            web_mem0   <= 1'b1;
            wmask_mem0 <= '0;
            addr_mem0  <= '0;
            din_mem0   <= '0;
            csb_mem1   <= 1'b1;
            web_mem1   <= 1'b1;
            wmask_mem1 <= '0;
            addr_mem1  <= '0;
            din_mem1   <= '0;
        end else begin
            csb_mem0 <= !(accept && !sel_mem1);
            web_mem0 <= !(accept && !sel_mem1);
            csb_mem1 <= !(accept && sel_mem1);
            web_mem1 <= !(accept && sel_mem1);
            if (accept && !sel_mem1) begin
                wmask_mem0 <= s_wmask;
                addr_mem0  <= addr_cnt[ADDR_W-2:0];
                din_mem0   <= s_data;
            end
            if (accept && sel_mem1) begin
                wmask_mem1 <= s_wmask;
                addr_mem1  <= addr_cnt[ADDR_W-2:0];
                din_mem1   <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_split_memory_writer.sv
// Directed and randomized bursts against a queue-based model of the expected macro writes.
module tb_split_memory_writer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic        abort;
    logic [9:0]  start_addr;
    logic [10:0] word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_wmask;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        csb_mem0, web_mem0, csb_mem1, web_mem1;
    logic [3:0]  wmask_mem0, wmask_mem1;
    logic [8:0]  addr_mem0, addr_mem1;
    logic [31:0] din_mem0, din_mem1;

    split_memory_writer #(.ADDR_W(10), .DATA_W(32)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_wmask    (s_wmask),
        .s_ready    (s_ready),
        .busy       (busy),
        .done       (done),
        .csb_mem0   (csb_mem0),
        .web_mem0   (web_mem0),
        .wmask_mem0 (wmask_mem0),
        .addr_mem0  (addr_mem0),
        .din_mem0   (din_mem0),
        .csb_mem1   (csb_mem1),
        .web_mem1   (web_mem1),
        .wmask_mem1 (wmask_mem1),
        .addr_mem1  (addr_mem1),
        .din_mem1   (din_mem1)
    );

    typedef struct packed {
        logic        mem;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] cyc;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [31:0] done_obs[$];
    logic [31:0] done_exp[$];
    logic [31:0] cyc = 0;
    int          bad_ctl = 0;
    int          checks = 0;
    int          failures = 0;

    localparam logic [101:0] RESET_VEC = {3'b000, 2'b11, 4'h0, 9'h0, 32'h0, 2'b11, 4'h0, 9'h0, 32'h0};

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Every cycle whose chip select is low is logged as one observed write.
    always @(negedge wb_clk_i) begin
        wr_t w;
        if (csb_mem0 === 1'b0 || web_mem0 === 1'b0) begin
            w = '{1'b0, addr_mem0, din_mem0, wmask_mem0, cyc};
            obs_q.push_back(w);
        end
        if (csb_mem1 === 1'b0 || web_mem1 === 1'b0) begin
            w = '{1'b1, addr_mem1, din_mem1, wmask_mem1, cyc};
            obs_q.push_back(w);
        end
        if (csb_mem0 !== web_mem0 || csb_mem1 !== web_mem1) bad_ctl++;
        if (done === 1'b1) done_obs.push_back(cyc);
    end

    function automatic logic [101:0] out_vec();
        return {s_ready, busy, done, csb_mem0, web_mem0, wmask_mem0, addr_mem0, din_mem0,
                csb_mem1, web_mem1, wmask_mem1, addr_mem1, din_mem1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    // vmode: 0 valid always high, 1 valid toggling, 2 random valid with stray start, 3 fixed 0xA0.. data
    task automatic burst(input logic [9:0] sa, input logic [10:0] wc, input int vmode,
                         input int abort_at, input int rst_at);
        int n;
        int acc;
        int guard;
        logic v;
        logic [31:0] d;
        logic [3:0] m;
        logic [9:0] a;
        wr_t w;
        n = (int'(wc) > 1024) ? 1024 : int'(wc);
        start = 1'b1;
        start_addr = sa;
        word_count = wc;
        s_valid = 1'b0;
        step();
        start = 1'b0;
        start_addr = 10'($urandom);
        word_count = 11'($urandom);
        if (n == 0) begin
            done_exp.push_back(cyc);
            chk("empty_busy", 128'(busy), 128'(1));
            step();
            return;
        end
        chk("run_busy", 128'(busy), 128'(1));
        acc = 0;
        guard = 0;
        while (acc < n && guard < 4000) begin
            guard++;
            d = $urandom;
            m = 4'($urandom);
            case (vmode)
                1:       v = (guard % 2) == 1;
                2:       v = 1'($urandom_range(0, 1));
                3:       begin v = 1'b1; d = 32'hA0 + 32'(acc); m = 4'hF; end
                default: v = 1'b1;
            endcase
            if (acc == abort_at) begin
                abort = 1'b1;
                s_valid = 1'b1;
                s_data = d;
                #1;
                chk("abort_ready", 128'(s_ready), 128'(0));
                step();
                abort = 1'b0;
                s_valid = 1'b0;
                chk("abort_idle", 128'({busy, done}), 128'(0));
                return;
            end
            if (acc == rst_at) begin
                wb_rst_i = 1'b1;
                s_valid = 1'b1;
                s_data = d;
                step();
                wb_rst_i = 1'b0;
                s_valid = 1'b0;
                chk("rst_outputs", 128'(out_vec()), 128'(RESET_VEC));
                return;
            end
            if (vmode == 2) start = 1'($urandom_range(0, 1));
            s_valid = v;
            s_data = d;
            s_wmask = m;
            #1;
            chk("run_ready", 128'({s_ready, busy}), 128'(2'b11));
            a = 10'((int'(sa) + acc) % 1024);
            step();
            if (v) begin
                w = '{a[9], a[8:0], d, m, cyc};
                exp_q.push_back(w);
                acc++;
                if (acc == n) done_exp.push_back(cyc);
            end
        end
        chk("burst_accepts", 128'(acc), 128'(n));
        start = 1'b0;
        s_valid = 1'b0;
        step();
    endtask

    task automatic finish_check(input string tag);
        repeat (3) step();
        chk({tag, "_nwr"}, 128'(obs_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_wr"}, 128'(obs_q[i]), 128'(exp_q[i]));
        chk({tag, "_ndone"}, 128'(done_obs.size()), 128'(done_exp.size()));
        for (int i = 0; i < done_obs.size() && i < done_exp.size(); i++)
            chk({tag, "_done_cyc"}, 128'(done_obs[i]), 128'(done_exp[i]));
        chk({tag, "_ctl"}, 128'(bad_ctl), 128'(0));
        chk({tag, "_idle"}, 128'({busy, done, s_ready}), 128'(0));
        obs_q.delete();
        exp_q.delete();
        done_obs.delete();
        done_exp.delete();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        word_count = '0;
        s_valid = 1'b0;
        s_data = '0;
        s_wmask = '0;
        repeat (2) step();
        chk("reset_state", 128'(out_vec()), 128'(RESET_VEC));
        wb_rst_i = 1'b0;
        obs_q.delete();
        done_obs.delete();
        bad_ctl = 0;
        step();

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_idle", 128'({busy, done}), 128'(0));

        burst(10'h000, 11'd4, 3, -1, -1);
        finish_check("mem0_run");

        burst(10'h1FE, 11'd4, 0, -1, -1);
        finish_check("cross_512");

        burst(10'h3FF, 11'd2, 0, -1, -1);
        finish_check("wrap_1023");

        burst(10'($urandom), 11'd4, 1, 2, -1);
        finish_check("abort");

        burst(10'($urandom), 11'd0, 0, -1, -1);
        finish_check("empty");

        burst(10'($urandom), 11'd2000, 0, -1, -1);
        finish_check("clamp");

        burst(10'($urandom), 11'd10, 0, -1, 3);
        finish_check("reset_mid");

        burst(10'h100, 11'd5, 0, -1, -1);
        finish_check("after_reset");

        for (int k = 0; k < 4; k++) begin
            burst(10'($urandom), 11'($urandom_range(1, 40)), 2, -1, -1);
            finish_check("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/split_memory_writer.md
SPLIT_MEMORY_WRITER -- requirements
Module: split_memory_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the logical word address width across both macros.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with all state updated on the rising edge of wb_clk_i.
REQ-004 SHALL have port wb_clk_i  in  1  clock.
REQ-005 SHALL have port wb_rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  single-cycle burst request, honoured only in IDLE.
REQ-007 SHALL have port abort  in  1  terminates the current burst.
REQ-008 SHALL have port start_addr  in  10  first logical word address, sampled on an accepted start.
REQ-009 SHALL have port word_count  in  11  words to write; values above 1024 are clamped to 1024; 0 means an empty burst.
REQ-010 SHALL have ports s_valid  in  1,  s_data  in  32  and  s_wmask  in  4, carrying the write stream (byte mask, 1 = write byte).
REQ-011 SHALL have port s_ready  out  1  stream accept.
REQ-012 SHALL have ports busy  out  1  and  done  out  1, where done is a one-cycle completion pulse.
REQ-013 SHALL have ports csb_memN  out  1,  web_memN  out  1,  wmask_memN  out  4,  addr_memN  out  9  and  din_memN  out  32, for N = 0 and 1, driving the write port of each 512x32 macro (csb and web active-low).

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on start with clamped word_count != 0; the address counter loads start_addr and the remaining counter loads the clamped count.
REQ-016 IDLE -> DONE on start with word_count == 0; no memory access is issued.
REQ-017 s_ready SHALL equal (state == RUN) && !abort; a word is accepted when s_valid && s_ready.
REQ-018 On an accepted word, the next cycle SHALL present csb_memS=0, web_memS=0, addr_memS=addr[8:0], din_memS=s_data and wmask_memS=s_wmask, where S = addr[9] of the accepted word; the other macro SHALL see csb=1, web=1 that cycle.
REQ-019 Cycles with no accepted word SHALL present csb=1 and web=1 to both macros, with addr, din and wmask held at their previous values.
REQ-020 Each accept SHALL increment the address modulo 1024 (1023 -> 0 wraps into mem0; 511 -> 512 switches to mem1) and decrement the remaining count.
REQ-021 The accept that brings the remaining count to 0 SHALL move the FSM RUN -> DONE; the last write is presented during the DONE cycle.
REQ-022 DONE SHALL last exactly one cycle, with done=1, then go to IDLE.
REQ-023 abort in RUN SHALL move the FSM to IDLE next cycle, accept no word that cycle and not pulse done; writes already accepted still complete.
REQ-024 start outside IDLE SHALL be ignored, as SHALL abort outside RUN.
REQ-025 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-026 Throughput SHALL be one word per cycle while s_valid stays high; s_valid low in RUN stalls the burst without a timeout.

Reset
REQ-027 wb_rst_i SHALL force IDLE, with s_ready=0, busy=0, done=0, csb_mem0/1=1, web_mem0/1=1, wmask=0, addr=0, din=0 and both counters=0, on the next edge.
REQ-028 Reset asserted mid-burst SHALL discard the burst; no write is presented in the cycle after reset.

Structure
REQ-029 Package split_memory_pkg SHALL hold the state enum, MEM_ADDR_W=9, MEM_DEPTH=512, TOTAL_DEPTH=1024 and MAX_COUNT=1024.
REQ-030 The block SHALL be a single module with no sub-module; all memory-port outputs SHALL be registered.

Verification
REQ-031 The bench SHALL apply start_addr=0x000, word_count=4 and data 0xA0..0xA3 with s_valid held high, and SHALL check mem0 writes at addr 0..3 on 4 consecutive cycles, done pulsing with the 4th write, and no mem1 access.
REQ-032 The bench SHALL apply start_addr=0x1FE, word_count=4, and SHALL check writes at mem0 0x1FE and 0x1FF, then mem1 0x000 and 0x001.
REQ-033 The bench SHALL apply start_addr=0x3FF, word_count=2, and SHALL check writes at mem1 0x1FF, then mem0 0x000 (wrap).
REQ-034 The bench SHALL apply word_count=4, s_valid toggling 1,0,1,0,..., and abort after the 2nd accept, and SHALL check exactly 2 writes, no done, and IDLE with busy=0.
REQ-035 The bench SHALL apply word_count=0, and SHALL check done one cycle after start with no csb asserted; it SHALL also check that word_count=2000 writes 1024 words.
REQ-036 The bench SHALL assert wb_rst_i after the 3rd accept of a 10-word burst, and SHALL check all outputs at reset values next cycle and that a following start works normally.
